multi_cyc_core: RTL and testbench
=================================

// Module: multi_cyc_core
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle addi datapath.
//  Fetches over a req/valid handshake and decodes ADDI/ADD/SUB/LUI/EBREAK.
//  Executes on an internal XLEN-wide register file, then writes back.
//  A FETCH/EXEC/WB/HALT FSM sequences each instruction; illegal opcodes halt.
//  Sits as the core top for npc; a sim-side instruction memory answers fetches.
// PARAMETERS
//  XLEN      64            datapath/register width (32 or 64)
//  PC_W      32            program counter width
//  RESET_PC  32'h8000_0000 pc after reset (PC_W bits)
// PORTS
//  clk         in   1     single clock, rising edge
//  rstn        in   1     synchronous active-low reset
//  inst_req    out  1     fetch request; high only in FETCH and when rstn=1
//  inst_addr   out  PC_W  fetch address (= pc), stable while inst_req=1
//  inst_valid  in   1     inst_data valid; sampled only while inst_req=1
//  inst_data   in   32    instruction word
//  result      out  XLEN  last ALU result (registered)
//  wb_valid    out  1     one-cycle pulse in the WB cycle
//  wb_addr     out  5     rd of the instruction in WB
//  halt        out  1     core stopped (EBREAK or illegal)
//  illegal     out  1     halt was caused by an unsupported encoding
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - pc=RESET_PC, state=FETCH, x1..x31=0, result=0, IR=0.
//   - wb_valid=0, wb_addr=0, halt=0, illegal=0.
//   - Reset overrides any state, including mid-fetch and HALT.
//  FETCH:
//   - inst_req=1, inst_addr=pc.
//   - On inst_valid=1: IR<=inst_data, go to EXEC.
//   - Else hold; inst_addr must not change while waiting.
//  EXEC: decode IR and register the ALU output into result.
//   - ADDI (op 0010011, f3 000): rs1 + sext(imm[11:0]).
//   - ADD (op 0110011, f3 000, f7 0000000): rs1 + rs2.
//   - SUB (same, f7 0100000): rs1 - rs2.
//   - LUI (op 0110111): sext({imm[31:12],12'b0}) to XLEN.
//   - EBREAK (0x00100073): next state HALT, halt<=1; result unchanged.
//   - Anything else: next state HALT, halt<=1, illegal<=1; result unchanged.
//   - Otherwise next state WB.
//  WB: wb_valid=1, wb_addr=rd, x[rd]<=result, pc<=pc+4, then FETCH.
//  HALT: absorbing until reset. inst_req=0, no regfile or pc change.
//  Latency: 3 cycles per instruction when inst_valid is given in the first FETCH cycle.
//  Widths:
//   - Add/sub wrap modulo 2^XLEN; no overflow flags.
//   - pc wraps modulo 2^PC_W.
//  x0: reads return 0. Writes to x0 still pulse wb_valid with wb_addr=0, but x0 stays 0.
//  inst_valid while inst_req=0 is ignored.
//  Register reads happen in EXEC, so a WB value is visible to the next instruction (no hazard).
// TESTING
//  1. Reset with inst_valid=1 and data 0x00500093.
//     -> inst_addr=0x80000000; WB: wb_addr=1, result=5.
//     -> next inst_addr=0x80000004.
//  2. Then 0xFFF08113 (addi x2,x1,-1) -> result=4.
//     Then 0x002081B3 (add) -> 9. Then 0x40208233 (sub) -> 1.
//  3. 0x800002B7 (lui x5,0x80000), XLEN=64 -> result=0xFFFFFFFF80000000.
//     Then addi x6,x0,-1 and add x7,x6,x6 -> 0xFFFFFFFFFFFFFFFE (wrap).
//  4. inst_valid withheld 4 cycles in FETCH.
//     -> inst_req=1 and inst_addr constant throughout; a valid pulse in EXEC is ignored.
//  5. 0x00100073 -> halt=1, illegal=0, wb_valid never pulses, inst_req stays 0.
//     Then 0xFFFFFFFF on a fresh run -> halt=1, illegal=1.
//  6. Write to x0 (0x00700013) -> wb_valid with wb_addr=0; add x1,x0,x0 -> result 0.
//     Then rstn=0 for 1 cycle during WAIT -> pc=0x80000000, halt=0, x1 reads 0.

Source files
------------

// File: rtl/multi_cyc_core.sv
// multi_cyc_core: multi-cycle RV-subset core (ADDI/ADD/SUB/LUI/EBREAK).
// Fetches one instruction word over a req/valid handshake, executes it
// against an internal XLEN-wide register file, then writes it back.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | inst_req high, waiting for inst_valid; pc held on inst_addr
// S_EXEC  | decode IR, register ALU output into result
// S_WB    | wb_valid pulse, x[rd] <= result, pc <= pc + 4
// S_HALT  | stopped after EBREAK or illegal encoding; left only by reset
module multi_cyc_core #(
  parameter int              XLEN     = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            inst_req,
  output logic [PC_W-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst_data,
  output logic [XLEN-1:0] result,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic            halt,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_REG  = 7'b0110011;
  localparam logic [6:0]  OP_LUI  = 7'b0110111;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [6:0]  F7_ADD  = 7'b0000000;
  localparam logic [6:0]  F7_SUB  = 7'b0100000;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [0:31];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] alu_out;
  logic            alu_ok;
  logic            is_ebreak;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  // x0 is forced to zero on read regardless of the array contents
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

  // Size casts of signed operands sign-extend, which also covers XLEN=32
  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));

  assign is_ebreak = (ir == EBREAK);

  assign inst_req  = rstn && (state == S_FETCH);
  assign inst_addr = pc;

  // Decode IR and compute the ALU result; alu_ok marks a supported encoding
  always_comb begin
    alu_out = '0;
    alu_ok  = 1'b0;
    unique case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          alu_out = rs1_val + imm_i;
          alu_ok  = 1'b1;
        end
      end
      OP_REG: begin
        if (funct3 == 3'b000 && funct7 == F7_ADD) begin
          alu_out = rs1_val + rs2_val;
          alu_ok  = 1'b1;
        end else if (funct3 == 3'b000 && funct7 == F7_SUB) begin
          alu_out = rs1_val - rs2_val;
          alu_ok  = 1'b1;
        end
      end
      OP_LUI: begin
        alu_out = imm_u;
        alu_ok  = 1'b1;
      end
      default: begin
        alu_out = '0;
        alu_ok  = 1'b0;
      end
    endcase
  end

  // Sequencer: state, pc, IR, register file and all registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      result   <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= 5'd0;
      halt     <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (inst_valid) begin
            ir    <= inst_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ebreak) begin
            halt  <= 1'b1;
            state <= S_HALT;
          end else if (!alu_ok) begin
            halt    <= 1'b1;
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            result   <= alu_out;
            wb_valid <= 1'b1;
            wb_addr  <= rd;
            state    <= S_WB;
          end
        end
        S_WB: begin
          if (wb_addr != 5'd0) begin
            rf[wb_addr] <= result;
          end
          pc    <= pc + PC_W'(4);
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cyc_core.sv
// Directed bench for multi_cyc_core: a table of instructions with
// hand-computed results, plus hand-written stall, halt, illegal and
// reset-in-flight sequences.
module tb_multi_cyc_core;

  localparam int XLEN = 64;
  localparam int PC_W = 32;
  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rstn;
  logic            inst_req;
  logic [PC_W-1:0] inst_addr;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] result;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic            halt;
  logic            illegal;

  int n_vec = 0;
  int n_bad = 0;

  multi_cyc_core #(.XLEN(XLEN), .PC_W(PC_W), .RESET_PC(PC0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .result     (result),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .halt       (halt),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [63:0] res;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Feed one instruction; called at a negedge with inst_valid low.
  task automatic run_inst(input logic [31:0] inst, input logic [31:0] exp_pc,
                          input int stall, input bit glitch,
                          input bit exp_wb, input logic [4:0] exp_rd,
                          input logic [63:0] exp_res, input bit exp_ill);
    int guard = 0;
    while (!inst_req && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("fetch_req", 64'(inst_req), 64'd1);
    check("fetch_addr", 64'(inst_addr), 64'(exp_pc));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req", 64'(inst_req), 64'd1);
      check("stall_addr", 64'(inst_addr), 64'(exp_pc));
    end
    inst_valid = 1'b1;
    inst_data  = inst;
    @(negedge clk);
    inst_valid = 1'b0;
    check("exec_req", 64'(inst_req), 64'd0);
    if (glitch) begin
      inst_valid = 1'b1;
      inst_data  = 32'h0010_0073;
    end
    @(negedge clk);
    inst_valid = 1'b0;
    check("wb_valid", 64'(wb_valid), 64'(exp_wb));
    if (exp_wb) check("wb_addr", 64'(wb_addr), 64'(exp_rd));
    check("result", result, exp_res);
    check("halt", 64'(halt), 64'(!exp_wb));
    check("illegal", 64'(illegal), 64'(exp_ill));
    @(negedge clk);
    check("wb_pulse_end", 64'(wb_valid), 64'd0);
    if (exp_wb) check("next_addr", 64'(inst_addr), 64'(exp_pc + 32'd4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0050_0093, 5'd1, 64'd5};
    vecs[1] = '{32'hFFF0_8113, 5'd2, 64'd4};
    vecs[2] = '{32'h0020_81B3, 5'd3, 64'd9};
    vecs[3] = '{32'h4020_8233, 5'd4, 64'd1};
    vecs[4] = '{32'h8000_02B7, 5'd5, 64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{32'hFFF0_0313, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{32'h0063_03B3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7] = '{32'h0070_0013, 5'd0, 64'd7};
    vecs[8] = '{32'h0000_0433, 5'd8, 64'd0};
    vecs[9] = '{32'h4010_04B3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFB};

    inst_valid = 1'b1;
    inst_data  = 32'h0050_0093;
    rstn       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(inst_req), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_addr", 64'(inst_addr), 64'(PC0));
    inst_valid = 1'b0;
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_inst(vecs[i].inst, PC0 + 32'(4 * i), 0, 1'b0, 1'b1,
               vecs[i].rd, vecs[i].res, 1'b0);
    end

    // addi x10,x1,16 with 4-cycle stall and a stray valid during EXEC
    run_inst(32'h0100_8513, PC0 + 32'd40, 4, 1'b1, 1'b1, 5'd10, 64'd21, 1'b0);

    // EBREAK: halt, no writeback, result kept, stays put
    run_inst(32'h0010_0073, PC0 + 32'd44, 0, 1'b0, 1'b0, 5'd0, 64'd21, 1'b0);
    inst_valid = 1'b1;
    inst_data  = 32'h0050_0093;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_req", 64'(inst_req), 64'd0);
      check("halt_wb", 64'(wb_valid), 64'd0);
      check("halt_hold", 64'(halt), 64'd1);
      check("halt_addr", 64'(inst_addr), 64'(PC0 + 32'd44));
    end
    inst_valid = 1'b0;

    // Reset out of HALT, then an illegal word
    do_reset();
    check("rst2_halt", 64'(halt), 64'd0);
    check("rst2_result", result, 64'd0);
    check("rst2_addr", 64'(inst_addr), 64'(PC0));
    run_inst(32'hFFFF_FFFF, PC0, 0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1);

    // Reset while waiting in FETCH clears x1
    do_reset();
    run_inst(32'h0050_0093, PC0, 0, 1'b0, 1'b1, 5'd1, 64'd5, 1'b0);
    repeat (2) @(negedge clk);
    check("wait_addr", 64'(inst_addr), 64'(PC0 + 32'd4));
    rstn = 1'b0;
    #1;
    check("rst_req_comb", 64'(inst_req), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    check("rst3_addr", 64'(inst_addr), 64'(PC0));
    check("rst3_halt", 64'(halt), 64'd0);
    run_inst(32'h0000_8133, PC0, 0, 1'b0, 1'b1, 5'd2, 64'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
